// File: rtl/inertial_integrator.sv
// rtl/inertial_integrator.sv - gyro pitch integrator with offset calibration; optional accel fusion via PTCH_FUSION_EN
module inertial_integrator #(
  parameter logic [15:0] PTCH_RT_OFFSET_DFLT = 16'h0050,
  parameter logic [15:0] AZ_OFFSET           = 16'h00A0,
  parameter int          FUSION_GAIN         = 1024,
  parameter int          CAL_LOG2            = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [15:0] ptch_rt_raw,
  input  logic [15:0] AZ,
  input  logic        cal_req,
  output logic [15:0] ptch,
  output logic [15:0] ptch_rt,
  output logic        ptch_vld,
  output logic        cal_busy,
  output logic        cal_done
);

  typedef enum logic {ST_RUN, ST_CAL} state_t;

  state_t               state_q, state_d;
  logic [15:0]          offset_q, offset_d;
  logic signed [26:0]   ptch_int_q, ptch_int_d;
  logic [15:0]          ptch_rt_q, ptch_rt_d;
  logic                 ptch_vld_q, ptch_vld_d;
  logic                 cal_busy_q, cal_busy_d;
  logic                 cal_done_q, cal_done_d;
  logic signed [23:0]   acc_q, acc_d;
  logic [CAL_LOG2-1:0]  cnt_q, cnt_d;

  logic signed [16:0]   diff;
  logic [15:0]          diff_sat;
  logic signed [27:0]   fusion;
  logic signed [27:0]   int_sum;
  logic signed [26:0]   int_sat;
  logic signed [23:0]   acc_sum;
  logic signed [23:0]   acc_shift;

  assign ptch = ptch_int_q[26:11];

  // offset-corrected rate in 17 bits, clamped back to 16
  always_comb begin
    diff = {ptch_rt_raw[15], ptch_rt_raw} - {offset_q[15], offset_q};
    if (diff[16] != diff[15]) begin
      diff_sat = diff[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      diff_sat = diff[15:0];
    end
  end

`ifdef PTCH_FUSION_EN
  logic [15:0]        az_comp;
  logic signed [25:0] prod;
  logic signed [15:0] ptch_acc;

  // accelerometer pitch estimate nudges the integrator toward itself by a fixed step
  always_comb begin
    az_comp  = AZ - AZ_OFFSET;
    prod     = $signed({{10{az_comp[15]}}, az_comp}) * 26'sd327;
    ptch_acc = {{3{prod[25]}}, prod[25:13]};
    if (ptch_acc > $signed(ptch)) begin
      fusion = 28'(FUSION_GAIN);
    end else if (ptch_acc < $signed(ptch)) begin
      fusion = -28'(FUSION_GAIN);
    end else begin
      fusion = '0;
    end
  end
`else
  logic unused_fusion;
  assign fusion        = '0;
  assign unused_fusion = ^{AZ, AZ_OFFSET, FUSION_GAIN[0]};
`endif

  // integrator step with clamp to the 27-bit signed range so pitch never wraps
  always_comb begin
    int_sum = {ptch_int_q[26], ptch_int_q} - {{12{diff_sat[15]}}, diff_sat} + fusion;
    if (int_sum[27] != int_sum[26]) begin
      int_sat = int_sum[27] ? 27'sh4000000 : 27'sh3FFFFFF;
    end else begin
      int_sat = int_sum[26:0];
    end
  end

  // calibration running sum and the averaged offset it would produce
  always_comb begin
    acc_sum   = acc_q + {{8{ptch_rt_raw[15]}}, ptch_rt_raw};
    acc_shift = acc_sum >>> CAL_LOG2;
  end

  // next-state: RUN integrates on vld, CAL accumulates and holds the integrator
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    ptch_int_d = ptch_int_q;
    ptch_rt_d  = ptch_rt_q;
    ptch_vld_d = 1'b0;
    cal_done_d = 1'b0;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (vld) begin
          ptch_rt_d  = diff_sat;
          ptch_int_d = int_sat;
          ptch_vld_d = 1'b1;
        end
        if (cal_req) begin
          state_d = ST_CAL;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_CAL: begin
        if (vld) begin
          if (cnt_q == '1) begin
            offset_d   = acc_shift[15:0];
            cal_done_d = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = ST_RUN;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CAL_LOG2'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
    cal_busy_d = (state_d == ST_CAL);
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      offset_q   <= PTCH_RT_OFFSET_DFLT;
      ptch_int_q <= '0;
      ptch_rt_q  <= '0;
      ptch_vld_q <= 1'b0;
      cal_busy_q <= 1'b0;
      cal_done_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      ptch_int_q <= ptch_int_d;
      ptch_rt_q  <= ptch_rt_d;
      ptch_vld_q <= ptch_vld_d;
      cal_busy_q <= cal_busy_d;
      cal_done_q <= cal_done_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ptch_rt  = ptch_rt_q;
  assign ptch_vld = ptch_vld_q;
  assign cal_busy = cal_busy_q;
  assign cal_done = cal_done_q;

endmodule

// File: doc/inertial_integrator.md
Name: inertial_integrator

Overview:
- Upstream stage of the PID controller; produces the signed pitch (ptch) and pitch rate (ptch_rt) that PID consumes.
- Removes the gyro pitch-rate offset and integrates the rate on each valid inertial sample.
- Optionally fuses in an accelerometer-derived pitch to cancel drift.
- Includes a run-time gyro offset calibration sequence that averages 2^CAL_LOG2 samples.

Parameters:
PTCH_RT_OFFSET_DFLT, 16'h0050, gyro offset used after reset until a calibration completes
AZ_OFFSET, 16'h00A0, accelerometer Z offset
FUSION_GAIN, 1024, magnitude of the per-sample fusion correction applied to the integrator
CAL_LOG2, 8, log2 of the number of samples averaged during calibration (256)

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  reset, asynchronous, active-high
vld  input  1  one-cycle strobe: ptch_rt_raw and AZ hold a new sample
ptch_rt_raw  input  16  signed raw gyro pitch rate
AZ  input  16  signed raw accelerometer Z
cal_req  input  1  one-cycle pulse requesting offset calibration
ptch  output  16  signed integrated pitch, equal to ptch_int[26:11]
ptch_rt  output  16  signed offset-corrected pitch rate (registered)
ptch_vld  output  1  one-cycle pulse; ptch and ptch_rt were updated this cycle
cal_busy  output  1  high while in the CAL state
cal_done  output  1  one-cycle pulse when a calibration completes

Behaviour:
- Reset (async, rst=1): state=RUN, offset=PTCH_RT_OFFSET_DFLT, ptch_int=0, ptch=0, ptch_rt=0, ptch_vld=0, cal_busy=0, cal_done=0, cal accumulator and counter cleared.
- States:
  - RUN: vld triggers an integrator update.
  - CAL: vld samples accumulate; the integrator holds.
- Transitions:
  - RUN to CAL on cal_req.
  - CAL to RUN after the 2^CAL_LOG2-th accepted sample.
  - cal_req while in CAL is ignored; the sequence does not restart.
- RUN, vld=1, all results registered at that edge:
  - diff = ptch_rt_raw - offset, computed in 17 bits.
  - ptch_rt is diff saturated to 16 bits: 0x7FFF or 0x8000 on overflow.
  - az_comp = AZ - AZ_OFFSET (16-bit wrap).
  - prod = az_comp * 327 (signed, 26 bits).
  - ptch_acc = sign-extended prod[25:13] (16 bits).
  - fusion = +FUSION_GAIN if ptch_acc > ptch, -FUSION_GAIN if ptch_acc < ptch, 0 if equal.
  - The comparison uses the pre-update registered ptch and the saturated diff.
  - ptch_int(next) = ptch_int - sign-extended sat(diff) + fusion, saturated to 27-bit signed (max 0x3FFFFFF, min 0x4000000); it never wraps.
  - ptch_vld = 1 the cycle after the vld edge, aligned with the new ptch and ptch_rt (latency 1 clock).
- CAL, vld=1:
  - acc (24-bit signed) += sign-extended ptch_rt_raw; cnt increments.
  - On the final sample: offset = acc >>> CAL_LOG2 (arithmetic, truncated); cal_done pulses 1 cycle; acc and cnt clear.
  - No ptch_vld pulses in CAL; ptch and ptch_rt hold their values.
- vld and cal_req in the same cycle in RUN: the sample is integrated with the old offset, then the state enters CAL; that sample is not counted toward calibration.
- vld is ignored when low; back-to-back vld on consecutive cycles is supported.
- Reset mid-calibration: returns to RUN with the default offset; the partial accumulation is discarded.

Optional Feature:
- Macro: PTCH_FUSION_EN.
- Defined: accelerometer fusion active as specified above.
- Undefined:
  - fusion is forced to 0 (pure gyro integration).
  - AZ is unused.
  - The multiplier and compare logic are not synthesized.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> ptch=0, ptch_rt=0, ptch_vld=0, cal_busy=0 immediately; offset=0x0050.
- Zero drift: 100 vld with ptch_rt_raw=0x0050, AZ=0x00A0 -> ptch_rt=0 and ptch=0 throughout; one ptch_vld per vld, 1-cycle latency.
- Integration: 16 vld with ptch_rt_raw=0xF850 (ptch_rt=-2048), AZ=0x00A0:
  - fusion undefined -> ptch=0x0010.
  - fusion defined -> ptch=0x0008 (ptch_int=2048+15*1024=17408).
- Calibration: cal_req pulse, then 256 vld with raw=0x0060 -> cal_busy high for the sequence, no ptch_vld, cal_done pulse; subsequent raw=0x0060 in RUN -> ptch_rt=0.
- Saturation (fusion undefined): raw=0x8000 repeatedly -> ptch_rt=0x8000; after 2047 samples ptch=0x7FF0; from 2048 on, ptch_int clamps at 0x3FFFFFF and ptch=0x7FFF with no wrap.
- Reset mid-cal: cal_req, 100 vld with raw=0x0100, assert rst -> state RUN, offset=0x0050, cal_done never pulses; raw=0x0050 then gives ptch_rt=0.
